// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a little-endian host byte stream into
// 32-bit words, writes them to instruction memory, then releases the core.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | after reset, waiting for start; core held
// S_LEN_LO | accepting low byte of the word count
// S_LEN_HI | accepting high byte of the word count, then range check
// S_DATA   | accepting the four bytes of the current word
// S_WRITE  | one-cycle memory write of the assembled word
// S_DONE   | load complete; core released
// S_ERR    | word count too large for memory; core held
module instr_loader #(
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              write_en,
  output logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] address,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   instr_in_q, instr_in_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          byte_ready_q, byte_ready_d;
  logic          write_en_q, write_en_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;

  logic          xfer;
  logic [15:0]   full_n;

  assign xfer   = byte_valid & byte_ready_q;
  assign full_n = {byte_in, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    instr_in_d = instr_in_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          addr_d  = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = full_n;
          if (full_n == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, full_n} > DEPTH_L) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_in;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Latch word and address here so both are stable across WRITE
            state_d    = S_WRITE;
            instr_in_d = word_d;
            addr_d     = wcnt_q[AW-1:0];
          end
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_q + 16'd1;
        if (wcnt_q + 16'd1 == len_q) state_d = S_DONE;
        else                         state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    write_en_d   = (state_d == S_WRITE);
    cpu_hold_d   = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
      instr_in_q   <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      write_en_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      instr_in_q   <= instr_in_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      write_en_q   <= write_en_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign write_en   = write_en_q;
  assign instr_in   = instr_in_q;
  assign address    = ADDR_W'(addr_q);
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: streams built from random words are
// compared against the expected list of (address, word) memory writes.
module tb_instr_loader;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        write_en;
  logic [31:0] instr_in;
  logic [31:0] address;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  instr_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .write_en(write_en),
    .instr_in(instr_in), .address(address), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_words[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          ready_in_write = 0;
  logic        prev_we = 1'b0;
  logic        post_done = 1'b0;
  logic        post_hold = 1'b1;

  // Memory-side monitor: records every write and the status right after it
  always @(negedge clk) begin
    if (write_en) begin
      got_addr.push_back(address);
      got_data.push_back(instr_in);
      if (byte_ready) ready_in_write <= ready_in_write + 1;
    end
    if (prev_we && !write_en) begin
      post_done <= load_done;
      post_hold <= cpu_hold;
    end
    prev_we <= write_en;
  end

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    ready_in_write = 0;
    post_done = 1'b0;
    post_hold = 1'b1;
  endtask

  // Byte stream from the declared count plus exp_words, little-endian
  task automatic make_stream(input int n);
    stream.delete();
    stream.push_back(8'(n % 256));
    stream.push_back(8'((n / 256) % 256));
    foreach (exp_words[i])
      for (int k = 0; k < 4; k++)
        stream.push_back(8'((exp_words[i] >> (8 * k)) & 32'hFF));
  endtask

  task automatic rand_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid toggles, 2: random valid and stray starts
  task automatic send_bytes(input int mode, input int limit);
    int idx = 0;
    int cyc = 0;
    int total = (limit < 0) ? stream.size() : limit;
    int bound = 20 * total + 100;
    bit v;
    while (idx < total && cyc < bound) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      start      = (mode == 2) && ($urandom_range(0, 5) == 0);
      byte_valid = v;
      byte_in    = v ? stream[idx] : 8'($urandom);
      if (v && byte_ready) idx++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    if (idx < total) begin
      checks++; errors++;
      $display("FAIL send_timeout sent %0d of %0d bytes", idx, total);
    end
  endtask

  task automatic wait_end(input string name);
    int cyc = 0;
    while (!(load_done || load_err) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (!(load_done || load_err)) begin
      checks++; errors++;
      $display("FAIL %s end_timeout load_done %b load_err %b", name, load_done, load_err);
    end
  endtask

  task automatic check_writes(input string name, input int n);
    int ne = (n == 0 || n > DEPTH) ? 0 : n;
    checks++;
    if (got_addr.size() != ne) begin
      errors++;
      $display("FAIL %s write_count got %0d exp %0d", name, got_addr.size(), ne);
    end
    for (int i = 0; i < ne && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== 32'(i) || got_data[i] !== exp_words[i]) begin
        errors++;
        $display("FAIL %s write[%0d] got addr %0d data %h exp addr %0d data %h",
                 name, i, got_addr[i], got_data[i], i, exp_words[i]);
      end
    end
  endtask

  task automatic check_done(input string name);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_status got done %b hold %b err %b rdy %b exp 1 0 0 0",
               name, load_done, cpu_hold, load_err, byte_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 ||
        address !== 32'd0 || instr_in !== 32'd0 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got hold %b rdy %b done %b err %b addr %h instr %h we %b exp 1 0 0 0 0 0 0",
               cpu_hold, byte_ready, load_done, load_err, address, instr_in, write_en);
    end
    checks++;
    if (got_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_no_writes got %0d exp 0", got_addr.size());
    end
  endtask

  task automatic test_two_word(input int mode, input string name);
    exp_words.delete();
    exp_words.push_back(32'h00000033);
    exp_words.push_back(32'h00400033);
    make_stream(2);
    clear_mon();
    pulse_start();
    send_bytes(mode, -1);
    wait_end(name);
    check_writes(name, 2);
    checks++;
    if (post_done !== 1'b1 || post_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s after_last_write got done %b hold %b exp 1 0", name, post_done, post_hold);
    end
    check_done(name);
    checks++;
    if (ready_in_write != 0) begin
      errors++;
      $display("FAIL %s ready_in_write got %0d exp 0", name, ready_in_write);
    end
  endtask

  task automatic test_oversize();
    int bad_rdy = 0;
    exp_words.delete();
    make_stream(513);
    clear_mon();
    pulse_start();
    send_bytes(0, -1);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL oversize_status got err %b hold %b rdy %b done %b exp 1 1 0 0",
               load_err, cpu_hold, byte_ready, load_done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      if (byte_ready) bad_rdy++;
    end
    @(negedge clk) byte_valid = 1'b0;
    checks++;
    if (bad_rdy != 0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL oversize_hold got ready_cycles %0d err %b exp 0 1", bad_rdy, load_err);
    end
    check_writes("oversize", 513);
    rand_words(3);
    make_stream(3);
    clear_mon();
    pulse_start();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL oversize_restart_clear got err %b exp 0", load_err);
    end
    send_bytes(2, -1);
    wait_end("oversize_reload");
    check_writes("oversize_reload", 3);
    check_done("oversize_reload");
  endtask

  task automatic test_zero();
    exp_words.delete();
    make_stream(0);
    clear_mon();
    pulse_start();
    send_bytes(0, -1);
    wait_end("zero");
    check_writes("zero", 0);
    check_done("zero");
  endtask

  task automatic test_full();
    rand_words(DEPTH);
    make_stream(DEPTH);
    clear_mon();
    pulse_start();
    send_bytes(0, -1);
    wait_end("full");
    check_writes("full", DEPTH);
    checks++;
    if (got_addr.size() == 0 || got_addr[got_addr.size() - 1] !== 32'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_last_addr got %0d exp %0d",
               (got_addr.size() == 0) ? -1 : int'(got_addr[got_addr.size() - 1]), DEPTH - 1);
    end
    check_done("full");
  endtask

  task automatic test_reset_mid();
    rand_words(1);
    make_stream(1);
    clear_mon();
    pulse_start();
    send_bytes(0, 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || write_en !== 1'b0 || load_done !== 1'b0 ||
        load_err !== 1'b0 || address !== 32'd0 || instr_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_values got hold %b rdy %b we %b done %b err %b addr %h instr %h exp 1 0 0 0 0 0 0",
               cpu_hold, byte_ready, write_en, load_done, load_err, address, instr_in);
    end
    @(negedge clk) rst_n = 1'b1;
    rand_words(2);
    make_stream(2);
    clear_mon();
    pulse_start();
    send_bytes(1, -1);
    wait_end("reset_mid_reload");
    check_writes("reset_mid_reload", 2);
    check_done("reset_mid_reload");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 12);
      rand_words(n);
      make_stream(n);
      clear_mon();
      pulse_start();
      send_bytes(2, -1);
      wait_end("random");
      check_writes("random", n);
      check_done("random");
      checks++;
      if (ready_in_write != 0) begin
        errors++;
        $display("FAIL random ready_in_write got %0d exp 0", ready_in_write);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word(0, "two_word");
    test_two_word(1, "stalls");
    test_oversize();
    test_zero();
    test_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
